// File: rtl/s_axi_mem_pkg.sv
// Shared widths, response codes and state encodings for the s_axi_mem slave.
package s_axi_mem_pkg;
    localparam int ID_WIDTH    = 4;
    localparam int AUSER_WIDTH = 1;
    localparam int WUSER_WIDTH = 1;
    localparam int BUSER_WIDTH = 1;
    localparam int RUSER_WIDTH = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;
endpackage

// File: rtl/s_axi_mem_if.sv
// AXI4 bus bundle between the traffic master and the s_axi_mem slave.
interface s_axi_mem_if
    import s_axi_mem_pkg::*;
#(
    parameter int DWIDTH = 32
);
    logic                   awvalid, awready;
    logic [ID_WIDTH-1:0]    awid;
    logic [DWIDTH-1:0]      awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awlock;
    logic [3:0]             awcache;
    logic [2:0]             awprot;
    logic [3:0]             awqos;
    logic [AUSER_WIDTH-1:0] awuser;

    logic                   wvalid, wready;
    logic [DWIDTH-1:0]      wdata;
    logic [DWIDTH/8-1:0]    wstrb;
    logic                   wlast;
    logic [WUSER_WIDTH-1:0] wuser;

    logic                   bvalid, bready;
    logic [ID_WIDTH-1:0]    bid;
    logic [1:0]             bresp;
    logic [BUSER_WIDTH-1:0] buser;

    logic                   arvalid, arready;
    logic [ID_WIDTH-1:0]    arid;
    logic [DWIDTH-1:0]      araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arlock;
    logic [3:0]             arcache;
    logic [2:0]             arprot;
    logic [3:0]             arqos;
    logic [AUSER_WIDTH-1:0] aruser;

    logic                   rvalid, rready;
    logic [ID_WIDTH-1:0]    rid;
    logic [DWIDTH-1:0]      rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic [RUSER_WIDTH-1:0] ruser;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awqos, awuser,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wuser,
        output wready,
        output bvalid, bid, bresp, buser,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arqos, aruser,
        output arready,
        output rvalid, rid, rdata, rresp, rlast, ruser,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awqos, awuser,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wuser,
        input  wready,
        input  bvalid, bid, bresp, buser,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arqos, aruser,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast, ruser,
        output rready
    );
endinterface

// File: rtl/s_axi_mem_ram.sv
// Byte-enable write, asynchronous read storage array; contents are not reset.
module s_axi_mem_ram #(
    parameter int DWIDTH = 32,
    parameter int MEM_AW = 10
) (
    input  logic                clk,
    input  logic [DWIDTH/8-1:0] we,
    input  logic [MEM_AW-1:0]   waddr,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic [MEM_AW-1:0]   raddr,
    output logic [DWIDTH-1:0]   rdata
);
    logic [DWIDTH-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DWIDTH/8; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/s_axi_mem.sv
// AXI4 slave memory: independent write and read burst engines over one RAM,
// SLVERR for bursts that start outside the window.
module s_axi_mem
    import s_axi_mem_pkg::*;
#(
    parameter int          DWIDTH    = 32,
    parameter int          MEM_AW    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input logic        clk,
    input logic        xrst,
    s_axi_mem_if.slave bus
);
    localparam int NB  = DWIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam logic [DWIDTH-1:0] BASE = DWIDTH'(BASE_ADDR);
    localparam logic [DWIDTH-1:0] WIN  = DWIDTH'(1) << (MEM_AW + LSB);
    localparam logic [DWIDTH-1:0] STEP = DWIDTH'(NB);

    function automatic logic out_of_range(input logic [DWIDTH-1:0] a);
        return (a - BASE) >= WIN;
    endfunction

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;
    logic    live;

    logic [ID_WIDTH-1:0] w_id, r_id;
    logic [DWIDTH-1:0]   w_addr, r_addr, r_addr_nxt, r_data;
    logic [7:0]          w_len, w_cnt, r_len, r_cnt;
    logic                w_fixed, w_oor, w_bad;
    logic                r_fixed, r_oor, r_last;
    logic                aw_hs, w_hs, w_end, ar_hs, r_hs;

    logic [NB-1:0]       ram_we;
    logic [MEM_AW-1:0]   ram_ra;
    logic [DWIDTH-1:0]   ram_rd;

    // Keeps awready/arready low while reset is held and for the first edge.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            live    <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            live    <= 1'b1;
        end
    end

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        aw_hs  = 1'b0;
        w_hs   = 1'b0;
        w_end  = 1'b0;
        ar_hs  = 1'b0;
        r_hs   = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_hs = live && bus.awvalid;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                w_hs  = bus.wvalid;
                w_end = w_hs && (bus.wlast || w_cnt == w_len);
                if (w_end) w_next = W_RESP;
            end
            W_RESP: if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
        unique case (r_state)
            R_IDLE: begin
                ar_hs = live && bus.arvalid;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                r_hs = bus.rready;
                if (r_hs && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign r_last     = r_cnt == r_len;
    assign r_addr_nxt = r_fixed ? r_addr : r_addr + STEP;
    assign ram_we     = (w_hs && !w_oor) ? bus.wstrb : '0;
    // Idle: look up the incoming burst start; busy: prefetch the next beat.
    assign ram_ra     = (r_state == R_IDLE) ? bus.araddr[LSB +: MEM_AW]
                                            : r_addr_nxt[LSB +: MEM_AW];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_oor   <= 1'b0;
            w_bad   <= 1'b0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_oor   <= 1'b0;
            r_data  <= '0;
        end else begin
            if (aw_hs) begin
                w_id    <= bus.awid;
                w_addr  <= bus.awaddr;
                w_len   <= bus.awlen;
                w_cnt   <= '0;
                w_fixed <= bus.awburst == BURST_FIXED;
                w_oor   <= out_of_range(bus.awaddr);
                w_bad   <= 1'b0;
            end
            if (w_hs) begin
                if (!w_fixed) w_addr <= w_addr + STEP;
                w_cnt <= w_cnt + 8'd1;
                if (bus.wlast != (w_cnt == w_len)) w_bad <= 1'b1;
            end
            if (ar_hs) begin
                r_id    <= bus.arid;
                r_addr  <= bus.araddr;
                r_len   <= bus.arlen;
                r_cnt   <= '0;
                r_fixed <= bus.arburst == BURST_FIXED;
                r_oor   <= out_of_range(bus.araddr);
                r_data  <= out_of_range(bus.araddr) ? '0 : ram_rd;
            end
            if (r_hs) begin
                r_addr <= r_addr_nxt;
                r_cnt  <= r_cnt + 8'd1;
                r_data <= r_oor ? '0 : ram_rd;
            end
        end
    end

    assign bus.awready = live && (w_state == W_IDLE);
    assign bus.wready  = w_state == W_DATA;
    assign bus.bvalid  = w_state == W_RESP;
    assign bus.bid     = w_id;
    assign bus.bresp   = (w_oor || w_bad) ? RESP_SLVERR : RESP_OKAY;
    assign bus.buser   = '0;
    assign bus.arready = live && (r_state == R_IDLE);
    assign bus.rvalid  = r_state == R_DATA;
    assign bus.rid     = r_id;
    assign bus.rdata   = r_data;
    assign bus.rresp   = r_oor ? RESP_SLVERR : RESP_OKAY;
    assign bus.rlast   = (r_state == R_DATA) && r_last;
    assign bus.ruser   = '0;

    logic unused;
    assign unused = ^{bus.awsize, bus.awlock, bus.awcache, bus.awprot,
                      bus.awqos, bus.awuser, bus.wuser, bus.arsize,
                      bus.arlock, bus.arcache, bus.arprot, bus.arqos,
                      bus.aruser};

    s_axi_mem_ram #(
        .DWIDTH(DWIDTH),
        .MEM_AW(MEM_AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(w_addr[LSB +: MEM_AW]),
        .wdata(bus.wdata),
        .raddr(ram_ra),
        .rdata(ram_rd)
    );
endmodule

// File: tb/tb_s_axi_mem.sv
// Bench for s_axi_mem: directed scenarios and random bursts checked
// against a plain word-array model of the memory window.
module tb_s_axi_mem;
    import s_axi_mem_pkg::*;

    localparam int          DW    = 32;
    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam int unsigned BASE  = 0;
    localparam logic [31:0] WINB  = 32'(DEPTH * 4);

    logic clk  = 1'b0;
    logic xrst = 1'b0;
    always #5 clk = ~clk;

    s_axi_mem_if #(.DWIDTH(DW)) bus ();

    s_axi_mem #(
        .DWIDTH(DW),
        .MEM_AW(AW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk (clk),
        .xrst(xrst),
        .bus (bus)
    );

    logic [31:0] model [DEPTH];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) % DEPTH;
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return (a - BASE) >= WINB;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_awready"}, bus.awready, 0);
        chk({tag, "_wready"},  bus.wready,  0);
        chk({tag, "_bvalid"},  bus.bvalid,  0);
        chk({tag, "_bid"},     bus.bid,     0);
        chk({tag, "_bresp"},   bus.bresp,   0);
        chk({tag, "_buser"},   bus.buser,   0);
        chk({tag, "_arready"}, bus.arready, 0);
        chk({tag, "_rvalid"},  bus.rvalid,  0);
        chk({tag, "_rid"},     bus.rid,     0);
        chk({tag, "_rdata"},   bus.rdata,   0);
        chk({tag, "_rresp"},   bus.rresp,   0);
        chk({tag, "_rlast"},   bus.rlast,   0);
        chk({tag, "_ruser"},   bus.ruser,   0);
    endtask

    // last_at: beat carrying wlast (>len means never); rst_at: beat at
    // which reset is pulsed (-1 for none).
    task automatic write_burst(input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input logic [3:0] id,
                               input int last_at, input logic [31:0] d0,
                               input bit rnd, input logic [3:0] strb,
                               input bit rnd_strb, input int bdelay,
                               input int rst_at);
        int n, beats, idx;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  eresp;
        beats = (last_at < len ? last_at : len) + 1;
        eresp = (oor(addr) || last_at != len) ? 2'b10 : 2'b00;
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        bus.awburst = burst;
        bus.awid    = id;
        bus.awsize  = 3'd2;
        n = 0;
        while (!bus.awready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("awready", bus.awready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        chk("wready_first", bus.wready, 1);
        idx = widx(addr);
        for (int i = 0; i < beats; i++) begin
            d = rnd ? $urandom : d0 + 32'(i);
            s = rnd_strb ? 4'($urandom) : strb;
            bus.wvalid = 1'b1;
            bus.wdata  = d;
            bus.wstrb  = s;
            bus.wlast  = (i == last_at);
            if (i == rst_at) begin
                #3 xrst = 1'b0;
                #1 chk_zero("rst_mid");
                bus.wvalid = 1'b0;
                bus.wlast  = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk) xrst = 1'b1;
                return;
            end
            chk("wready", bus.wready, 1);
            @(posedge clk); #1;
            if (!oor(addr))
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("wready_done", bus.wready, 0);
        n = 0;
        while (!bus.bvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("bvalid", bus.bvalid, 1);
        for (int k = 0; k < bdelay; k++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", bus.bvalid, 1);
            chk("bid_hold", bus.bid, id);
            chk("bresp_hold", bus.bresp, eresp);
        end
        chk("bid", bus.bid, id);
        chk("bresp", bus.bresp, eresp);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        chk("awready_after_b", bus.awready, 1);
    endtask

    // mode 0: rready always 1; 1: random; 2: repeating 1-0-0-1.
    task automatic read_burst(input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic [3:0] id,
                              input int mode);
        int n, idx, cyc;
        bit hs, bad;
        logic [31:0] ed;
        logic [1:0]  eresp;
        logic [3:0]  pat;
        pat   = 4'b1001;
        bad   = oor(addr);
        eresp = bad ? 2'b10 : 2'b00;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arburst = burst;
        bus.arid    = id;
        bus.arsize  = 3'd2;
        n = 0;
        while (!bus.arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        idx = widx(addr);
        cyc = 0;
        for (int i = 0; i <= len; i++) begin
            ed = bad ? 32'h0 : model[idx];
            do begin
                case (mode)
                    0:       hs = 1'b1;
                    1:       hs = ($urandom_range(0, 3) != 0);
                    default: hs = pat[3 - (cyc % 4)];
                endcase
                bus.rready = hs;
                chk("rvalid", bus.rvalid, 1);
                chk("rdata", bus.rdata, ed);
                chk("rresp", bus.rresp, eresp);
                chk("rlast", bus.rlast, (i == len));
                chk("rid", bus.rid, id);
                @(posedge clk); #1;
                cyc++;
            end while (!hs);
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        end
        bus.rready = 1'b0;
        chk("rvalid_end", bus.rvalid, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          len, last;
        logic [1:0]  bt;

        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
        bus.awsize = 0; bus.awburst = 0; bus.awlock = 0; bus.awcache = 0;
        bus.awprot = 0; bus.awqos = 0; bus.awuser = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.wuser = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0;
        bus.arsize = 0; bus.arburst = 0; bus.arlock = 0; bus.arcache = 0;
        bus.arprot = 0; bus.arqos = 0; bus.aruser = 0; bus.rready = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) xrst = 1'b1;

        // Loopback fill: word i holds i.
        for (int k = 0; k < 4; k++)
            write_burst(32'(k * 1024), 255, 2'b01, 4'(k), 255,
                        32'(k * 256), 0, 4'hF, 0, 0, -1);
        for (int k = 0; k < 4; k++)
            read_burst(32'(k * 1024), 255, 2'b01, 4'(k + 4), 0);

        write_burst(32'h100, 3, 2'b01, 4'h9, 3, 0, 1, 4'hF, 0, 5, -1);
        read_burst(32'h40, 7, 2'b01, 4'h3, 2);

        write_burst(BASE + 32'h1000, 3, 2'b01, 4'h5, 3, 0, 1, 4'hF, 0, 0, -1);
        read_burst(BASE + 32'h1000, 3, 2'b01, 4'h6, 0);
        read_burst(32'h0, 3, 2'b01, 4'h7, 0);

        write_burst(32'h200, 7, 2'b01, 4'hA, 3, 0, 1, 4'hF, 0, 0, -1);
        read_burst(32'h200, 7, 2'b01, 4'hB, 1);

        write_burst(32'h300, 0, 2'b01, 4'hC, 0, 32'hFFFF_FFFF, 0,
                    4'b0011, 0, 0, -1);
        read_burst(32'h300, 0, 2'b01, 4'hD, 0);

        write_burst(32'h400, 255, 2'b01, 4'h1, 255, 0, 1, 4'hF, 0, 0, 100);
        write_burst(32'h400, 255, 2'b01, 4'h2, 255, 0, 1, 4'hF, 0, 0, -1);
        read_burst(32'h400, 255, 2'b01, 4'h2, 1);

        for (int t = 0; t < 40; t++) begin
            a    = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            if ($urandom_range(0, 7) == 0) a = a + WINB;
            len  = $urandom_range(0, 15);
            bt   = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            last = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len + 1)
                                               : len;
            write_burst(a, len, bt, 4'($urandom), last, 0, 1, 4'hF, 1,
                        $urandom_range(0, 2), -1);
            a  = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            if ($urandom_range(0, 7) == 0) a = a + WINB;
            bt = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            read_burst(a, $urandom_range(0, 15), bt, 4'($urandom), 1);
        end

        for (int k = 0; k < 4; k++)
            read_burst(32'(k * 1024), 255, 2'b01, 4'(k), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
